// File: rtl/div_seq_if.sv
// ----------------------------------------------------------------------------
// div_seq_if
//   Handshake bundle between the EX stage and the DIV/DIVU sequencer.
//   master : EX stage side (drives request/operands, observes result/stall)
//   slave  : divider side
//   Signals:
//     start_i      divide request, held until ready_o is seen
//     signed_i     1 = DIV (two's complement), 0 = DIVU
//     opdata1_i    dividend
//     opdata2_i    divisor
//     annul_i      cancel the current operation
//     result_o     {HI=remainder, LO=quotient}, valid while ready_o=1
//     ready_o      result valid
//     stall_req_o  pipeline hold request
//     div_zero_o   result came from a zero divisor, valid with ready_o
// ----------------------------------------------------------------------------
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stall_req_o;
  logic               div_zero_o;

  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stall_req_o, div_zero_o
  );

  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stall_req_o, div_zero_o
  );
endinterface

// File: rtl/div_seq.sv
// ----------------------------------------------------------------------------
// div_seq
//   Multi-cycle DIV/DIVU sequencer: radix-2 restoring divider producing one
//   quotient bit per clock. Owns the {HI,LO} result handed to the HI/LO write
//   path and holds the pipeline through stall_req_o until the result is ready.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-low reset
//     bus   div_seq_if.slave (request, operands, annul, result, ready, stall,
//           divide-by-zero flag)
//
//   state  | meaning
//   FREE   | idle, waiting for an un-annulled start
//   BYZERO | divisor was zero; result forced to 0 on the next edge
//   ON     | iterating, one quotient bit per edge; final edge applies sign fix
//   END    | result valid, held until start_i is sampled low
// ----------------------------------------------------------------------------
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  div_seq_if.slave    bus
);

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BYZERO = 2'b01,
    ON     = 2'b10,
    END    = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_dividend;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_result;
  logic               r_div_zero;

  logic               w_accept;
  logic               w_last_step;
  logic               w_neg_op1;
  logic               w_neg_op2;
  logic [WIDTH-1:0]   w_abs_op1;
  logic [WIDTH-1:0]   w_abs_op2;
  logic [WIDTH:0]     w_shifted;
  logic [WIDTH:0]     w_trial;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_accept    = (r_state == FREE) && bus.start_i && !bus.annul_i;
  assign w_last_step = (r_cnt == CNT_W'(WIDTH));

  // Magnitudes are captured once; the most negative value maps onto itself,
  // which is the correct unsigned magnitude for the iteration.
  assign w_neg_op1 = bus.signed_i && bus.opdata1_i[WIDTH-1];
  assign w_neg_op2 = bus.signed_i && bus.opdata2_i[WIDTH-1];
  assign w_abs_op1 = w_neg_op1 ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
  assign w_abs_op2 = w_neg_op2 ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and try subtracting the divisor with one extra bit of headroom.
  assign w_shifted = {r_rem, r_dividend[WIDTH-1]};
  assign w_trial   = w_shifted - {1'b0, r_divisor};

  assign w_quo_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FREE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FREE: begin
        if (w_accept) begin
          w_next_state = (bus.opdata2_i == '0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        w_next_state = bus.annul_i ? FREE : END;
      end
      ON: begin
        if (bus.annul_i) begin
          w_next_state = FREE;
        end else if (w_last_step) begin
          w_next_state = END;
        end
      end
      END: begin
        if (bus.annul_i || !bus.start_i) begin
          w_next_state = FREE;
        end
      end
      default: w_next_state = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_result   <= '0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        FREE: begin
          r_result   <= '0;
          r_div_zero <= 1'b0;
          if (w_accept) begin
            r_dividend <= w_abs_op1;
            r_divisor  <= w_abs_op2;
            r_neg_q    <= w_neg_op1 ^ w_neg_op2;
            r_neg_r    <= w_neg_op1;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
          end
        end
        BYZERO: begin
          r_cnt    <= '0;
          r_result <= '0;
          // The flag is only raised when the zero-divisor result is presented.
          r_div_zero <= !bus.annul_i;
        end
        ON: begin
          if (bus.annul_i) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_result <= '0;
          end else if (w_last_step) begin
            r_cnt    <= '0;
            r_result <= {w_rem_fix, w_quo_fix};
          end else begin
            r_cnt      <= r_cnt + CNT_W'(1);
            r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
            if (!w_trial[WIDTH]) begin
              r_rem <= w_trial[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
              r_rem <= w_shifted[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
          end
        end
        END: begin
          if (bus.annul_i || !bus.start_i) begin
            r_cnt      <= '0;
            r_result   <= '0;
            r_div_zero <= 1'b0;
          end
        end
        default: begin
          r_cnt      <= '0;
          r_result   <= '0;
          r_div_zero <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result_o    = r_result;
  assign bus.ready_o     = (r_state == END);
  assign bus.div_zero_o  = r_div_zero;
  assign bus.stall_req_o = bus.start_i && !bus.annul_i && (r_state != END);

endmodule

// File: tb/tb_div_seq.sv
// ----------------------------------------------------------------------------
// tb_div_seq
//   Directed-vector bench for div_seq with hand-computed expected results.
// ----------------------------------------------------------------------------
module tb_div_seq;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  div_seq_if #(.WIDTH(32)) bus ();

  div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one divide with start held, checks latency, stall, result, hold and
  // the return to idle once start drops.
  task automatic run_div(input string tag, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input logic exp_dz, input int exp_lat);
    int   n;
    logic stall_ok;
    bus.start_i   = 1'b1;
    bus.signed_i  = sgn;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.annul_i   = 1'b0;
    #1;
    check({tag, ":stall_rise"}, 64'(bus.stall_req_o), 64'd1);
    tick();
    // operands must be ignored once accepted
    bus.opdata1_i = $urandom;
    bus.opdata2_i = $urandom;
    n        = 1;
    stall_ok = 1'b1;
    while (bus.ready_o !== 1'b1 && n < 100) begin
      if (bus.stall_req_o !== 1'b1) stall_ok = 1'b0;
      tick();
      n++;
    end
    check({tag, ":latency"}, 64'(n), 64'(exp_lat));
    check({tag, ":stall_hold"}, 64'(stall_ok), 64'd1);
    check({tag, ":stall_ready"}, 64'(bus.stall_req_o), 64'd0);
    check({tag, ":result"}, bus.result_o, {exp_hi, exp_lo});
    check({tag, ":div_zero"}, 64'(bus.div_zero_o), 64'(exp_dz));
    tick();
    check({tag, ":ready_held"}, 64'(bus.ready_o), 64'd1);
    check({tag, ":result_held"}, bus.result_o, {exp_hi, exp_lo});
    bus.start_i = 1'b0;
    tick();
    check({tag, ":ready_clr"}, 64'(bus.ready_o), 64'd0);
    check({tag, ":result_clr"}, bus.result_o, 64'd0);
    check({tag, ":dz_clr"}, 64'(bus.div_zero_o), 64'd0);
  endtask

  // Watches ready_o for a number of cycles; it must stay low throughout.
  task automatic expect_quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.ready_o !== 1'b0) seen = 1'b1;
    end
    check({tag, ":no_ready"}, 64'(seen), 64'd0);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b0;
    bus.start_i   = 1'b0;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.annul_i   = 1'b0;
    #12;
    check("rst:result", bus.result_o, 64'd0);
    check("rst:ready", 64'(bus.ready_o), 64'd0);
    check("rst:stall", 64'(bus.stall_req_o), 64'd0);
    check("rst:dz", 64'(bus.div_zero_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    run_div("divu_17_3", 1'b0, 32'h11, 32'h3, 32'h5, 32'h2, 1'b0, 34);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
    run_div("div_7_m2", 1'b1, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 1'b0, 34);
    run_div("divu_zero", 1'b0, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 1'b1, 2);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 34);
    run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h7, 32'h2492_4924, 32'h3, 1'b0, 34);

    // annul with start in FREE: request ignored
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    #1;
    check("annul_free:stall", 64'(bus.stall_req_o), 64'd0);
    tick();
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    expect_quiet("annul_free", 40);

    // annul at E10 of DIVU 100/7
    bus.start_i = 1'b1;
    tick();
    for (int i = 1; i < 10; i++) tick();
    bus.annul_i = 1'b1;
    #1;
    check("annul_on:stall", 64'(bus.stall_req_o), 64'd0);
    tick();
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    check("annul_on:ready", 64'(bus.ready_o), 64'd0);
    check("annul_on:result", bus.result_o, 64'd0);
    expect_quiet("annul_on", 40);
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);

    // async reset at E20 of a divide
    bus.start_i   = 1'b1;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    for (int i = 0; i <= 20; i++) @(posedge clk);
    #2;
    rst         = 1'b0;
    bus.start_i = 1'b0;
    #1;
    check("rst_mid:ready", 64'(bus.ready_o), 64'd0);
    check("rst_mid:result", bus.result_o, 64'd0);
    check("rst_mid:stall", 64'(bus.stall_req_o), 64'd0);
    check("rst_mid:dz", 64'(bus.div_zero_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    expect_quiet("rst_mid", 40);
    run_div("divu_after_rst", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 34);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
